// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
// Segment encodings use logical polarity: a lit segment is 1, with a in bit 0.
package seven_seg_pkg;

   typedef enum logic {BLANK, DRIVE} state_t;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Hex glyphs 0-9, A, b, C, d, E, F.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seven_seg_scan_hex_to_7seg.sv
// Combinational nibble-to-glyph decode with logical (active-high) segment output.
module hex_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for common-anode 7-segment digits with frame-synchronous capture.
// Define SEVSEG_LZ_BLANK_EN to suppress leading zeros (digit 0 is always shown).
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit SEG_ACT_LOW  = 1'b1,
   parameter bit AN_ACT_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] disp,
   input  logic                    disp_valid,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W:0]   BLANK_LEN = (CNT_W+1)'(BLANK_CYCLES);

   logic [CNT_W-1:0]          cnt, cnt_next;
   logic [IDX_W-1:0]          idx, idx_next;
   state_t                    state, state_next;
   logic [4*NUM_DIGITS-1:0]   shadow;
   logic                      slot_end, frame_end;
   logic [NUM_DIGITS-1:0]     show;
   logic [3:0]                cur_digit;
   logic [6:0]                seg_logic;
   logic                      digit_on;
   logic [NUM_DIGITS-1:0]     an_logic;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         idx    <= '0;
         state  <= BLANK;
         shadow <= '0;
      end else begin
         cnt   <= cnt_next;
         idx   <= idx_next;
         state <= state_next;
         if (frame_end && disp_valid) begin
            shadow <= disp;
         end
      end
   end

   // Slot timing: each slot opens with a blank window so the previous digit's
   // segments never ghost onto the newly enabled anode.
   always_comb begin
      cnt_next   = slot_end ? '0 : cnt + 1'b1;
      idx_next   = idx;
      state_next = state;
      if (slot_end) begin
         idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      case (state)
         BLANK:   if ({1'b0, cnt_next} >= BLANK_LEN) state_next = DRIVE;
         DRIVE:   if (slot_end && (BLANK_CYCLES > 0)) state_next = BLANK;
         default: state_next = BLANK;
      endcase
   end

   always_comb begin
      show = '1;
`ifdef SEVSEG_LZ_BLANK_EN
      begin
         logic nz;
         nz = 1'b0;
         for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            nz      = nz | (shadow[4*k +: 4] != 4'h0);
            show[k] = nz;
         end
      end
`endif
   end

   assign cur_digit = shadow[{idx, 2'b00} +: 4];

   hex_to_7seg u_decode (
      .hex (cur_digit),
      .seg (seg_logic)
   );

   assign digit_on = (state == DRIVE) && show[idx];
   assign an_logic = digit_on ? (NUM_DIGITS'(1) << idx) : '0;

   // Pins are a registered copy of the current slot, so they trail the counters
   // by one cycle; frame_tick is registered from the upcoming count instead so
   // that it coincides with the capture cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         an         <= {NUM_DIGITS{AN_ACT_LOW}};
         seg        <= SEG_OFF ^ {7{SEG_ACT_LOW}};
         frame_tick <= 1'b0;
      end else begin
         an         <= an_logic ^ {NUM_DIGITS{AN_ACT_LOW}};
         seg        <= (digit_on ? seg_logic : SEG_OFF) ^ {7{SEG_ACT_LOW}};
         frame_tick <= (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised self-checking bench for seven_seg_scan against a cycle-position reference model.
module tb_seven_seg_scan;

   localparam int ND    = 6;
   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = ND * DIV;

   logic          clk = 1'b0;
   logic          rst;
   logic [23:0]   disp;
   logic          disp_valid;
   logic [6:0]    seg;
   logic [5:0]    an;
   logic          frame_tick;

   int            vectors = 0;
   int            miscompares = 0;

   int            m_p;
   logic [23:0]   m_shadow;
   logic [5:0]    exp_an;
   logic [6:0]    exp_seg;
   logic          exp_tick;
   logic [6:0]    lut [16];

   seven_seg_scan #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (DIV),
      .BLANK_CYCLES (BLK),
      .SEG_ACT_LOW  (1'b1),
      .AN_ACT_LOW   (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .disp       (disp),
      .disp_valid (disp_valid),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Pins that a cycle at frame position p, showing word sh, calls for.
   function automatic void model_pins(input int p, input logic [23:0] sh,
                                      output logic [5:0] m_an, output logic [6:0] m_seg);
      int digit_pos, in_slot;
      logic [23:0] upper;
      logic show;
      digit_pos = p / DIV;
      in_slot   = p % DIV;
      upper     = sh >> (4 * digit_pos);
      show      = (in_slot >= BLK);
`ifdef SEVSEG_LZ_BLANK_EN
      if (digit_pos > 0 && upper == 24'h0) show = 1'b0;
`endif
      m_an  = show ? ~(6'b000001 << digit_pos) : 6'h3F;
      m_seg = show ? ~lut[upper[3:0]] : 7'h7F;
   endfunction

   // Advance one clock: the model tracks frame position and the displayed word;
   // pins for the new cycle describe the cycle just finished.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         m_p      = 0;
         m_shadow = 24'h0;
         exp_an   = 6'h3F;
         exp_seg  = 7'h7F;
         exp_tick = 1'b0;
      end else begin
         model_pins(m_p, m_shadow, exp_an, exp_seg);
         if (m_p == FRAME - 1 && disp_valid) m_shadow = disp;
         m_p      = (m_p + 1) % FRAME;
         exp_tick = (m_p == FRAME - 1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; disp = 24'h0; disp_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if ({an, seg, frame_tick} !== {6'h3F, 7'h7F, 1'b0}) begin
            miscompares++;
            $display("FAIL reset an=%h seg=%h tick=%b, want an=3f seg=7f tick=0", an, seg, frame_tick);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_first_frame();
      disp = 24'h123456; disp_valid = 1'b1;
      for (int i = 1; i <= FRAME + 8; i++) begin
         step();
         vectors++;
         if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
            miscompares++;
            $display("FAIL first_frame cyc=%0d got an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                     i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
         end
         if (i == 47 && frame_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL first_tick cyc=47 tick=%b, want 1", frame_tick);
         end
         if ((i == 49 || i == 50) && an !== 6'h3F) begin
            miscompares++;
            $display("FAIL slot0_blank cyc=%0d an=%h, want 3f", i, an);
         end
         if (i >= 51 && i <= 56 && {an, seg} !== {6'h3E, 7'h02}) begin
            miscompares++;
            $display("FAIL slot0_drive cyc=%0d an=%h seg=%h, want an=3e seg=02", i, an, seg);
         end
      end
   endtask

   task automatic test_hold();
      disp = 24'hFFFFFF; disp_valid = 1'b0;
      for (int i = 0; i < FRAME + 10; i++) begin
         step();
         vectors++;
         if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
            miscompares++;
            $display("FAIL hold got an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                     an, seg, frame_tick, exp_an, exp_seg, exp_tick);
         end
      end
   endtask

   task automatic test_no_tearing();
      disp = 24'h123456; disp_valid = 1'b0;
      for (int i = 0; i < 2 * FRAME && m_p != 2 * DIV; i++) step();
      vectors++;
      if (m_p != 2 * DIV) begin
         miscompares++;
         $display("FAIL tearing_sync pos=%0d, want %0d", m_p, 2 * DIV);
      end
      disp = 24'hABCDEF; disp_valid = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         vectors++;
         if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
            miscompares++;
            $display("FAIL no_tearing got an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                     an, seg, frame_tick, exp_an, exp_seg, exp_tick);
         end
      end
   endtask

   task automatic test_zero_digits();
      disp = 24'h000A05; disp_valid = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         vectors++;
         if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
            miscompares++;
            $display("FAIL zero_digits got an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                     an, seg, frame_tick, exp_an, exp_seg, exp_tick);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int i = 0; i < 6 * FRAME; i++) begin
         r          = $urandom;
         disp       = r[23:0] >> (4 * $urandom_range(0, 5));
         disp_valid = $urandom_range(0, 1) == 1;
         step();
         vectors++;
         if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
            miscompares++;
            $display("FAIL random got an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                     an, seg, frame_tick, exp_an, exp_seg, exp_tick);
         end
      end
   endtask

   task automatic test_mid_reset();
      disp = 24'h987654; disp_valid = 1'b1;
      for (int i = 0; i < 2 * FRAME && !(m_p == 3 * DIV + 5 && m_shadow != 0); i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if ({an, seg, frame_tick} !== {6'h3F, 7'h7F, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_reset_off an=%h seg=%h tick=%b, want an=3f seg=7f tick=0", an, seg, frame_tick);
      end
      for (int i = 1; i <= FRAME + 4; i++) begin
         step();
         vectors++;
         if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_tick}) begin
            miscompares++;
            $display("FAIL mid_reset cyc=%0d got an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                     i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
         end
         if (i <= 47 && frame_tick !== (i == 47)) begin
            miscompares++;
            $display("FAIL mid_reset_tick cyc=%0d tick=%b, want %b", i, frame_tick, i == 47);
         end
      end
   endtask

   initial begin
      lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      m_p = 0; m_shadow = 24'h0; exp_an = 6'h3F; exp_seg = 7'h7F; exp_tick = 1'b0;
      test_reset();
      test_first_frame();
      test_hold();
      test_no_tearing();
      test_zero_digits();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
